cam_cfg_sequencer: RTL and testbench

//  Walks a camera register table and issues one SCCB write per entry to the I2C/SCCB master over a req/ack handshake.

---
 rtl/cam_cfg_pkg.sv | 25 ++
 rtl/cam_cfg_rom.sv | 50 +++++
 rtl/cam_cfg_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cam_cfg_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera register-table sequencer.
package cam_cfg_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_PWRUP, S_FETCH, S_DECODE, S_ISSUE, S_WAIT,
    S_DELAY, S_NEXT, S_DONE, S_ERROR
`ifdef CAM_CFG_READBACK_EN
    , S_VERIFY
`endif
  } cfg_state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  localparam logic [7:0] CFG_END_REG = 8'hFF;
  localparam logic [7:0] CFG_END_DAT = 8'hFF;
  localparam logic [7:0] CFG_DLY_REG = 8'hF0;

  function automatic logic is_end(input cfg_entry_t e);
    return (e.reg_addr == CFG_END_REG) && (e.data == CFG_END_DAT);
  endfunction

endpackage

// File: rtl/cam_cfg_rom.sv
// Register table ROM, 1-cycle synchronous read.
// TABLE_SEL = 0: OV7670 RGB565 bring-up; TABLE_SEL = 1: short bring-up/test table.
module cam_cfg_rom import cam_cfg_pkg::*; #(
  parameter int TABLE_DEPTH = 128,
  parameter int TABLE_SEL   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [$clog2(TABLE_DEPTH)-1:0] addr,
  output cfg_entry_t                     entry
);

  function automatic cfg_entry_t rom_word(input int a);
    logic [15:0] w;
    w = 16'hFFFF;
    if (TABLE_SEL == 1) begin
      case (a)
        0: w = 16'h1280;  1: w = 16'h1101;  2: w = 16'hF003;
        3: w = 16'h0C04;  4: w = 16'hF000;  5: w = 16'h3E19;
        default: w = 16'hFFFF;
      endcase
    end else begin
      case (a)
        0:  w = 16'h1280;  1:  w = 16'hF00A;  // COM7 soft reset, then settle
        2:  w = 16'h1204;  3:  w = 16'h1101;  // RGB output, clock prescale
        4:  w = 16'h0C00;  5:  w = 16'h3E00;
        6:  w = 16'h0400;  7:  w = 16'h40D0;  // COM15: RGB565 full range
        8:  w = 16'h3A04;  9:  w = 16'h1418;
        10: w = 16'h4FB3;  11: w = 16'h50B3;  12: w = 16'h5100;  // colour matrix
        13: w = 16'h523D;  14: w = 16'h53A7;  15: w = 16'h54E4;
        16: w = 16'h589E;  17: w = 16'h3DC0;
        18: w = 16'h1714;  19: w = 16'h1802;  20: w = 16'h3280;  // window
        21: w = 16'h1903;  22: w = 16'h1A7B;  23: w = 16'h030A;
        24: w = 16'h0F41;  25: w = 16'h1E00;  26: w = 16'h330B;
        27: w = 16'h3C78;  28: w = 16'h6900;  29: w = 16'h7400;
        30: w = 16'hB084;  31: w = 16'hB10C;  32: w = 16'hB20E;
        33: w = 16'hB380;
        default: w = 16'hFFFF;
      endcase
    end
    return cfg_entry_t'(w);
  endfunction

  // Registered table read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) entry <= '0;
    else       entry <= rom_word(int'(addr));
  end

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks the camera register table and issues one SCCB write per entry over
// a req/ack handshake, with in-table ms delays and bounded NACK retry.
// Optional build macro CAM_CFG_READBACK_EN: read back each written register
// and flag a mismatch as an error.
module cam_cfg_sequencer import cam_cfg_pkg::*; #(
  parameter int          CLK_FREQ_HZ = 50_000_000,
  parameter logic [7:0]  DEV_ADDR    = 8'h42,
  parameter int          TABLE_DEPTH = 128,
  parameter int          MAX_RETRY   = 3,
  parameter int          PWRUP_MS    = 10,
  parameter int          TABLE_SEL   = 0,
  localparam int         IDX_W       = $clog2(TABLE_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             m_req,
  output logic             m_rd,
  output logic [7:0]       m_dev,
  output logic [7:0]       m_reg,
  output logic [7:0]       m_wdata,
  input  logic             m_ack,
  input  logic             m_nack,
  input  logic [7:0]       m_rdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx,
  output logic [IDX_W-1:0] cur_idx
);

  localparam int TICK_MAX = CLK_FREQ_HZ / 1000 - 1;
  localparam int TICK_W   = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
  localparam int RTY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int MS_W     = 16;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(TABLE_DEPTH - 1);

  cfg_state_t        state, state_nxt, retry_st, ok_st;
  cfg_entry_t        entry;
  logic              start_q, launch, enter_tmr;
  logic [TICK_W-1:0] tick_cnt;
  logic [MS_W-1:0]   ms_cnt;
  logic [RTY_W-1:0]  retry;

  cam_cfg_rom #(.TABLE_DEPTH(TABLE_DEPTH), .TABLE_SEL(TABLE_SEL)) u_rom (
    .clk(clk), .reset(reset), .addr(cur_idx), .entry(entry)
  );

  assign launch    = start & ~start_q;
  assign enter_tmr = (state_nxt != state) && (state_nxt == S_PWRUP || state_nxt == S_DELAY);
  assign busy      = !(state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);

`ifdef CAM_CFG_READBACK_EN
  // m_rd doubles as the "read phase" flag for the entry in flight.
  assign retry_st = m_rd ? S_VERIFY : S_ISSUE;
  assign ok_st    = !m_rd ? S_VERIFY : ((m_rdata != entry.data) ? S_ERROR : S_NEXT);

  // Read phase: set when the readback is issued, cleared per new entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   m_rd <= 1'b0;
    else if (state == S_DECODE)  m_rd <= 1'b0;
    else if (state == S_VERIFY)  m_rd <= 1'b1;
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^m_rdata;
  assign retry_st     = S_ISSUE;
  assign ok_st        = S_NEXT;
  assign m_rd         = 1'b0;
`endif

  // Start edge detector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (launch) state_nxt = S_PWRUP;
      S_PWRUP:  if (ms_cnt == MS_W'(PWRUP_MS)) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_end(entry))                     state_nxt = S_DONE;
        else if (entry.reg_addr == CFG_DLY_REG) state_nxt = S_DELAY;
        else                                   state_nxt = S_ISSUE;
      end
      S_ISSUE:  state_nxt = S_WAIT;
`ifdef CAM_CFG_READBACK_EN
      S_VERIFY: state_nxt = S_WAIT;
`endif
      S_WAIT: begin
        if (m_ack) begin
          if (m_nack) state_nxt = (retry < RTY_W'(MAX_RETRY)) ? retry_st : S_ERROR;
          else        state_nxt = ok_st;
        end
      end
      S_DELAY:  if (ms_cnt == {8'd0, entry.data}) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = (cur_idx == LAST) ? S_DONE : S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Free-running ms tick, restarted whenever a timed wait begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (enter_tmr) begin
      tick_cnt <= '0;
      ms_cnt   <= '0;
    end else if (tick_cnt == TICK_W'(TICK_MAX)) begin
      tick_cnt <= '0;
      ms_cnt   <= ms_cnt + 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Retry counter: fresh budget per entry (and per readback).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) retry <= '0;
    else if (state == S_DECODE) retry <= '0;
    else if (state == S_WAIT && m_ack) begin
      if (!m_nack)                          retry <= '0;
      else if (retry < RTY_W'(MAX_RETRY))   retry <= retry + 1'b1;
    end
  end

  // Request: rises leaving ISSUE/VERIFY, drops the cycle after ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) m_req <= 1'b0;
`ifdef CAM_CFG_READBACK_EN
    else if (state == S_ISSUE || state == S_VERIFY) m_req <= 1'b1;
`else
    else if (state == S_ISSUE) m_req <= 1'b1;
`endif
    else if (state == S_WAIT && m_ack) m_req <= 1'b0;
  end

  // Bus fields, table index and error index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_dev   <= '0;
      m_reg   <= '0;
      m_wdata <= '0;
      cur_idx <= '0;
      err_idx <= '0;
    end else begin
      if (state_nxt == S_PWRUP && state != S_PWRUP) begin
        cur_idx <= '0;
        err_idx <= '0;
      end
      if (state == S_DECODE && state_nxt == S_ISSUE) begin
        m_dev   <= DEV_ADDR;
        m_reg   <= entry.reg_addr;
        m_wdata <= entry.data;
      end
      if (state == S_NEXT && cur_idx != LAST) cur_idx <= cur_idx + 1'b1;
      if (state_nxt == S_ERROR && state != S_ERROR) err_idx <= cur_idx;
    end
  end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer on the short table (TABLE_SEL = 1), 1 MHz clock.
// A master model answers requests with random latency and scripted NACKs;
// expected traffic is derived from the table and the NACK script.
module tb_cam_cfg_sequencer;
  localparam int DEPTH = 8;
  localparam int MAXR  = 3;
  localparam int TPM   = 1000;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic m_ack = 1'b0, m_nack = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic m_req, m_rd, busy, done, error;
  logic [7:0] m_dev, m_reg, m_wdata;
  logic [2:0] err_idx, cur_idx;

  cam_cfg_sequencer #(
    .CLK_FREQ_HZ(1_000_000), .DEV_ADDR(8'h42), .TABLE_DEPTH(DEPTH),
    .MAX_RETRY(MAXR), .PWRUP_MS(1), .TABLE_SEL(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .m_req(m_req), .m_rd(m_rd), .m_dev(m_dev), .m_reg(m_reg), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_nack(m_nack), .m_rdata(m_rdata),
    .busy(busy), .done(done), .error(error), .err_idx(err_idx), .cur_idx(cur_idx)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl [DEPTH] = '{16'h1280, 16'h1101, 16'hF003, 16'h0C04,
                               16'hF000, 16'h3E19, 16'hFFFF, 16'hFFFF};
  int nk [256];
  bit bad_rd = 1'b0;
  int lat_lo = 1, lat_hi = 6;
  int run_id = 0;
  int spur_at = -1;

  int cyc = 0;
  int dev_bad = 0;
  logic [16:0] req_q [$];
  int req_cyc [$];
  int ack_cyc [$];
  bit rsp_pending = 1'b0;
  int rsp_wcnt = 0;
  int rsp_last_run = -1;
  int rsp_tries [256];

  logic [16:0] exp_q [$];
  bit exp_err;
  int exp_eidx, exp_last;

  int checks = 0, errors = 0;

  // Master model: logs each request, acks after a random latency.
  always begin
    @(negedge clk);
    cyc++;
    m_ack = 1'b0; m_nack = 1'b0;
    if (rsp_last_run != run_id) begin
      rsp_last_run = run_id;
      for (int i = 0; i < 256; i++) rsp_tries[i] = 0;
    end
    if (reset) begin
      if (rsp_pending) ack_cyc.push_back(-1);
      rsp_pending = 1'b0;
    end else if (cyc == spur_at) begin
      m_ack = 1'b1;
    end else if (rsp_pending) begin
      if (rsp_wcnt > 1) rsp_wcnt--;
      else begin
        m_ack = 1'b1; rsp_pending = 1'b0; ack_cyc.push_back(cyc);
        if (m_rd) m_rdata = (bad_rd && m_reg == 8'h12) ? (m_wdata ^ 8'h01) : m_wdata;
        else begin
          rsp_tries[m_reg]++;
          m_nack = (rsp_tries[m_reg] <= nk[m_reg]);
        end
      end
    end else if (m_req) begin
      rsp_pending = 1'b1;
      rsp_wcnt = $urandom_range(lat_hi, lat_lo);
      req_q.push_back({m_rd, m_reg, m_wdata});
      req_cyc.push_back(cyc);
      if (m_dev !== 8'h42) dev_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected traffic: each write entry takes min(nacks+1, MAXR+1) attempts.
  task automatic model();
    logic [7:0] r, d;
    int n;
    exp_q.delete(); exp_err = 1'b0; exp_eidx = 0; exp_last = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      r = tbl[i][15:8]; d = tbl[i][7:0];
      if (r == 8'hFF && d == 8'hFF) begin exp_last = i; break; end
      if (r != 8'hF0) begin
        n = (nk[r] > MAXR) ? MAXR + 1 : nk[r] + 1;
        for (int k = 0; k < n; k++) exp_q.push_back({1'b0, r, d});
        if (nk[r] > MAXR) begin exp_err = 1'b1; exp_eidx = i; exp_last = i; break; end
`ifdef CAM_CFG_READBACK_EN
        exp_q.push_back({1'b1, r, d});
        if (bad_rd && r == 8'h12) begin exp_err = 1'b1; exp_eidx = i; exp_last = i; break; end
`endif
      end
    end
  endtask

  task automatic run(input string tag, input bit repulse, input bit spurious, output int base);
    int n, t0;
    bit rep_did;
    model();
    run_id++;
    base = req_q.size();
    rep_did = 1'b0;
    @(negedge clk); start = 1'b1; t0 = cyc;
    if (spurious) spur_at = cyc + 20;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_run"}, {busy, done, error}, 3'b100);
    n = 0;
    while (!(done || error) && n < 20000) begin
      @(negedge clk); n++;
      if (repulse && !rep_did && req_q.size() >= base + 2) begin
        rep_did = 1'b1; start = 1'b1; @(negedge clk); start = 1'b0;
      end
    end
    chk({tag, "_finished"}, n < 20000, 1);
    repeat (30) @(negedge clk);
    chk({tag, "_nreq"}, req_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < req_q.size(); i++)
      chk({tag, "_req"}, req_q[base + i], exp_q[i]);
    if (exp_q.size() > 0 && req_q.size() > base)
      chk({tag, "_pwrup"}, (req_cyc[base] - t0 >= TPM) && (req_cyc[base] - t0 <= TPM + 20), 1);
    chk({tag, "_flags"}, {m_req, busy, done, error}, {2'b00, !exp_err, exp_err});
    chk({tag, "_err_idx"}, err_idx, exp_err ? exp_eidx : 0);
    chk({tag, "_cur_idx"}, cur_idx, exp_last);
    chk({tag, "_dev"}, dev_bad, 0);
  endtask

  task automatic gap_chk(input string tag, input int base, input logic [7:0] r, input int lo, input int hi);
    int k, g;
    k = -1;
    for (int i = base + 1; i < req_q.size(); i++) if (k < 0 && req_q[i][15:8] == r) k = i;
    g = -1;
    if (k > 0) g = req_cyc[k] - ack_cyc[k - 1];
    chk(tag, (g >= lo) && (g <= hi), 1);
  endtask

  initial begin
    int b, n;
    for (int i = 0; i < 256; i++) nk[i] = 0;
    #1;
    chk("rst_ctl", {m_req, m_rd, busy, done, error, err_idx, cur_idx}, 0);
    chk("rst_bus", {m_dev, m_reg, m_wdata}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle", {busy, done, error, m_req}, 0);

    // Plain walk, fixed 5-cycle master, spurious ack during power-up.
    lat_lo = 5; lat_hi = 5;
    run("basic", 1'b0, 1'b1, b);
    gap_chk("dly3_gap", b, 8'h0C, 3 * TPM, 3 * TPM + 20);
    gap_chk("dly0_gap", b, 8'h3E, 2, 20);

    lat_lo = 1; lat_hi = 6;
    nk[8'h11] = 2;
    run("nack2", 1'b0, 1'b0, b);
    nk[8'h11] = 9;
    run("nack_exhaust", 1'b0, 1'b0, b);
    nk[8'h11] = 0;

    for (int r = 0; r < 3; r++) begin
      nk[8'h12] = $urandom_range(4, 0); nk[8'h11] = $urandom_range(4, 0);
      nk[8'h0C] = $urandom_range(4, 0); nk[8'h3E] = $urandom_range(4, 0);
      run("rand", 1'b0, 1'b0, b);
    end
    for (int i = 0; i < 256; i++) nk[i] = 0;

    run("repulse", 1'b1, 1'b0, b);

    // Reset while a transfer is outstanding.
    run_id++;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!m_req && n < 3000) begin @(negedge clk); n++; end
    chk("rstwait_req_seen", m_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstwait_ctl", {m_req, m_rd, busy, done, error, err_idx, cur_idx}, 0);
    chk("rstwait_bus", {m_dev, m_reg, m_wdata}, 0);
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    run("restart", 1'b0, 1'b0, b);

`ifdef CAM_CFG_READBACK_EN
    bad_rd = 1'b1;
    run("rb_bad", 1'b0, 1'b0, b);
    bad_rd = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
